// File: rtl/bemf_pkg.sv
// Shared constants for the back-EMF sampling scheduler: widths, FSM state codes
// and the ADC channel encoding.
package bemf_pkg;
  localparam int BEMF_W  = 36;
  localparam int ADC_W   = 10;
  localparam int NUM_MOT = 4;
  localparam int MOT_W   = 2;
  localparam int CHAN_W  = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_REQ_H   = 3'd2;
  localparam logic [2:0] S_WAIT_H  = 3'd3;
  localparam logic [2:0] S_REQ_L   = 3'd4;
  localparam logic [2:0] S_WAIT_L  = 3'd5;
  localparam logic [2:0] S_ISSUE   = 3'd6;
  localparam logic [2:0] S_WAIT_WB = 3'd7;

  localparam logic SIDE_H = 1'b0;
  localparam logic SIDE_L = 1'b1;

  function automatic logic [CHAN_W-1:0] chan_enc(input logic [MOT_W-1:0] mot, input logic side);
    return {1'b0, mot, side};
  endfunction
endpackage

// File: rtl/bemf_regfile.sv
// Small per-motor register file: one write port, two async read ports, a
// per-entry synchronous clear (clear beats write) and the full contents.
module bemf_regfile
  import bemf_pkg::*;
#(
  parameter int W  = BEMF_W,
  parameter int N  = NUM_MOT,
  parameter int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [W-1:0]        wdata,
  input  logic [N-1:0]        clr,
  input  logic [AW-1:0]       raddr_a,
  output logic [W-1:0]        rdata_a,
  input  logic [AW-1:0]       raddr_b,
  output logic [W-1:0]        rdata_b,
  output logic [N-1:0][W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr[i])                       q[i] <= '0;
        else if (we && waddr == AW'(i))   q[i] <= wdata;
      end
    end
  end

  assign rdata_a = q[raddr_a];
  assign rdata_b = q[raddr_b];
endmodule

// File: rtl/bemf_scheduler.sv
// Round-robin back-EMF sampler for four motors: settle, sample high/low side,
// issue to the update stage and wait for its write-back.
// Optional feature: define BEMF_ACC_CLEAR_EN to add the acc_clear port.
module bemf_scheduler
  import bemf_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      adc_req,
  output logic [CHAN_W-1:0]         adc_chan,
  input  logic                      adc_ack,
  input  logic [ADC_W-1:0]          adc_data,
  output logic [ADC_W-1:0]          bemf_adc_h,
  output logic [ADC_W-1:0]          bemf_adc_l,
  output logic [MOT_W-1:0]          mot_sel,
  output logic                      out_valid,
  output logic [BEMF_W-1:0]         bemf_acc,
  output logic [BEMF_W-1:0]         bemf_calib,
  input  logic                      calib_wr,
  input  logic [MOT_W-1:0]          calib_sel,
  input  logic [BEMF_W-1:0]         calib_data,
  input  logic                      upd_valid,
  input  logic [MOT_W-1:0]          upd_sel,
  input  logic [BEMF_W-1:0]         upd_bemf,
`ifdef BEMF_ACC_CLEAR_EN
  input  logic [NUM_MOT-1:0]        acc_clear,
`endif
  output logic [NUM_MOT*BEMF_W-1:0] bemf_pos
);
  logic [2:0]                     state;
  logic [MOT_W-1:0]               motor;
  logic [7:0]                     cnt;
  logic [ADC_W-1:0]               h_cap;
  logic                           wb_discard;
  logic [NUM_MOT-1:0]             clr;
  logic                           wb_hit, acc_we, low_side;
  logic [BEMF_W-1:0]              acc_rd, cal_rd, acc_rd_unused, cal_rd_unused;
  logic [NUM_MOT-1:0][BEMF_W-1:0] acc_q, cal_q_unused;

`ifdef BEMF_ACC_CLEAR_EN
  assign clr = acc_clear;
`else
  assign clr = '0;
`endif

  assign wb_hit = (state == S_WAIT_WB) && upd_valid && (upd_sel == motor);
  // A clear seen while waiting poisons that motor's write-back, not just the current cycle.
  assign acc_we = upd_valid && !(wb_hit && wb_discard);

  bemf_regfile u_acc (
    .clk, .rst_n, .we(acc_we), .waddr(upd_sel), .wdata(upd_bemf), .clr,
    .raddr_a(motor), .rdata_a(acc_rd), .raddr_b(upd_sel), .rdata_b(acc_rd_unused),
    .q(acc_q)
  );

  bemf_regfile u_cal (
    .clk, .rst_n, .we(calib_wr), .waddr(calib_sel), .wdata(calib_data), .clr('0),
    .raddr_a(motor), .rdata_a(cal_rd), .raddr_b(calib_sel), .rdata_b(cal_rd_unused),
    .q(cal_q_unused)
  );

  assign bemf_pos = acc_q;
  assign low_side = (state == S_REQ_L) || (state == S_WAIT_L);
  assign adc_req  = (state == S_REQ_H) || (state == S_WAIT_H) || low_side;
  assign adc_chan = adc_req ? chan_enc(motor, low_side ? SIDE_L : SIDE_H) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      motor      <= '0;
      cnt        <= '0;
      h_cap      <= '0;
      wb_discard <= 1'b0;
      out_valid  <= 1'b0;
      mot_sel    <= '0;
      bemf_adc_h <= '0;
      bemf_adc_l <= '0;
      bemf_acc   <= '0;
      bemf_calib <= '0;
    end else begin
      out_valid  <= 1'b0;
      wb_discard <= (state == S_WAIT_WB) && !wb_hit && (wb_discard || clr[motor]);
      case (state)
        S_IDLE: if (enable) begin
          state <= S_SETTLE;
          cnt   <= 8'(SETTLE_CYCLES);
        end
        // Counter hits zero as REQ_H is entered: SETTLE occupies SETTLE_CYCLES cycles.
        S_SETTLE: if (cnt <= 8'd1) begin
          cnt   <= '0;
          state <= S_REQ_H;
        end else begin
          cnt <= cnt - 8'd1;
        end
        S_REQ_H:  state <= S_WAIT_H;
        S_WAIT_H: if (adc_ack) begin
          h_cap <= adc_data;
          state <= S_REQ_L;
        end
        S_REQ_L:  state <= S_WAIT_L;
        S_WAIT_L: if (adc_ack) begin
          state      <= S_ISSUE;
          out_valid  <= 1'b1;
          mot_sel    <= motor;
          bemf_adc_h <= h_cap;
          bemf_adc_l <= adc_data;
          bemf_acc   <= acc_rd;
          bemf_calib <= cal_rd;
        end
        S_ISSUE:  state <= S_WAIT_WB;
        S_WAIT_WB: if (wb_hit) begin
          motor <= motor + 2'd1;
          if (enable) begin
            state <= S_SETTLE;
            cnt   <= 8'(SETTLE_CYCLES);
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bemf_scheduler.sv
// Directed/randomised bench for bemf_scheduler with a per-motor array model of
// accumulators and calibration words.
module tb_bemf_scheduler;
  localparam int SETTLE = 4;

  logic         clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic         adc_ack = 1'b0, calib_wr = 1'b0, upd_valid = 1'b0;
  logic [9:0]   adc_data = '0;
  logic [1:0]   calib_sel = '0, upd_sel = '0;
  logic [35:0]  calib_data = '0, upd_bemf = '0;
  logic         adc_req, out_valid;
  logic [3:0]   adc_chan;
  logic [9:0]   bemf_adc_h, bemf_adc_l;
  logic [1:0]   mot_sel;
  logic [35:0]  bemf_acc, bemf_calib;
  logic [143:0] bemf_pos;
`ifdef BEMF_ACC_CLEAR_EN
  logic [3:0]   acc_clear = '0;
`endif

  bemf_scheduler #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .adc_req(adc_req), .adc_chan(adc_chan), .adc_ack(adc_ack), .adc_data(adc_data),
    .bemf_adc_h(bemf_adc_h), .bemf_adc_l(bemf_adc_l), .mot_sel(mot_sel),
    .out_valid(out_valid), .bemf_acc(bemf_acc), .bemf_calib(bemf_calib),
    .calib_wr(calib_wr), .calib_sel(calib_sel), .calib_data(calib_data),
    .upd_valid(upd_valid), .upd_sel(upd_sel), .upd_bemf(upd_bemf),
`ifdef BEMF_ACC_CLEAR_EN
    .acc_clear(acc_clear),
`endif
    .bemf_pos(bemf_pos)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [35:0] acc_m [4];
  logic [35:0] cal_m [4];
  int          mot_m = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [143:0] pos_m();
    return {acc_m[3], acc_m[2], acc_m[1], acc_m[0]};
  endfunction

  function automatic logic [3:0] chan_of(input int m, input logic side);
    return {1'b0, 2'(m), side};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin acc_m[i] = '0; cal_m[i] = '0; end
    mot_m = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   144'(adc_req),    144'(0));
    chk({tag, "_chan"},  144'(adc_chan),   144'(0));
    chk({tag, "_ov"},    144'(out_valid),  144'(0));
    chk({tag, "_sel"},   144'(mot_sel),    144'(0));
    chk({tag, "_h"},     144'(bemf_adc_h), 144'(0));
    chk({tag, "_l"},     144'(bemf_adc_l), 144'(0));
    chk({tag, "_acc"},   144'(bemf_acc),   144'(0));
    chk({tag, "_calib"}, 144'(bemf_calib), 144'(0));
    chk({tag, "_pos"},   bemf_pos,         144'(0));
  endtask

  // Wait for a request on the expected channel, hold it dly cycles, then ack.
  task automatic serve(input logic [3:0] exp_chan, input logic [9:0] val, input int dly, input bit drop_en);
    int n = 0;
    while (adc_req !== 1'b1 && n < 500) begin step(); n++; end
    chk("req_seen", 144'(adc_req), 144'(1));
    chk("adc_chan", 144'(adc_chan), 144'(exp_chan));
    for (int i = 0; i < dly; i++) begin
      step();
      if (drop_en && i == 0) enable = 1'b0;
      chk("req_held", 144'({adc_req, adc_chan}), 144'({1'b1, exp_chan}));
    end
    adc_data = val; adc_ack = 1'b1;
    step();
    adc_ack = 1'b0; adc_data = 10'($urandom);
  endtask

  task automatic latency_check(input string tag);
    int lat = 0;
    enable = 1'b1;
    while (adc_req !== 1'b1 && lat < 100) begin step(); lat++; end
    chk(tag, 144'(lat), 144'(SETTLE + 1));
  endtask

  task automatic run_sample(input logic [9:0] h, input logic [9:0] l, input int wb_dly,
                            input bit drop_en, input bit poke);
    int m = mot_m;
    int o = (mot_m + 1) % 4;
    logic [35:0] nv, cal_iss, ov;
    serve(chan_of(m, 1'b0), h, 1 + int'($urandom_range(0, 3)), drop_en);
    serve(chan_of(m, 1'b1), l, 1 + int'($urandom_range(0, 3)), 1'b0);
    chk("out_valid", 144'(out_valid),  144'(1));
    chk("mot_sel",   144'(mot_sel),    144'(m));
    chk("adc_h",     144'(bemf_adc_h), 144'(h));
    chk("adc_l",     144'(bemf_adc_l), 144'(l));
    chk("acc_iss",   144'(bemf_acc),   144'(acc_m[m]));
    chk("cal_iss",   144'(bemf_calib), 144'(cal_m[m]));
    cal_iss = cal_m[m];
    nv = acc_m[m] + 36'(h) - 36'(l) - cal_iss;
    step();
    chk("ov_pulse", 144'(out_valid), 144'(0));
    if (poke) begin
      ov = {4'(o), 32'($urandom)};
      calib_wr = 1'b1; calib_sel = 2'(m); calib_data = {4'h0, 32'($urandom)};
      upd_valid = 1'b1; upd_sel = 2'(o); upd_bemf = ov;
      step();
      calib_wr = 1'b0; upd_valid = 1'b0;
      cal_m[m] = calib_data; acc_m[o] = ov;
      chk("cal_hold", 144'(bemf_calib), 144'(cal_iss));
      chk("pos_other", bemf_pos, pos_m());
    end
    repeat (wb_dly) step();
    chk("no_req_wb", 144'(adc_req), 144'(0));
    upd_valid = 1'b1; upd_sel = 2'(m); upd_bemf = nv;
    step();
    upd_valid = 1'b0;
    acc_m[m] = nv; mot_m = (m + 1) % 4;
    chk("pos_wb", bemf_pos, pos_m());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int reqs;
    model_reset();
    repeat (3) step();
    chk_all_zero("rst");
    rst_n = 1'b1;
    step();

    // Preload while idle: calib[2]=5, acc[2]=1000, others random
    for (int i = 0; i < 4; i++) begin
      calib_wr = 1'b1; calib_sel = 2'(i); calib_data = (i == 2) ? 36'd5 : 36'($urandom_range(0, 50));
      upd_valid = 1'b1; upd_sel = 2'(i); upd_bemf = (i == 2) ? 36'd1000 : 36'($urandom);
      step();
      cal_m[i] = calib_data; acc_m[i] = upd_bemf;
    end
    calib_wr = 1'b0; upd_valid = 1'b0;
    chk("preload_pos", bemf_pos, pos_m());

    // Stray ack while idle is ignored
    adc_data = 10'd777; adc_ack = 1'b1; step(); adc_ack = 1'b0;
    step();
    chk("idle_ack", 144'(adc_req), 144'(0));

    latency_check("settle_lat");
    run_sample(10'd600, 10'd100, 2, 1'b0, 1'b0);
    run_sample(10'($urandom), 10'($urandom), 1, 1'b0, 1'b0);
    run_sample(10'd300, 10'd100, 3, 1'b0, 1'b0);
    chk("acc2_1195", 144'(bemf_pos[107:72]), 144'(1195));
    run_sample(10'($urandom), 10'($urandom), 0, 1'b0, 1'b0);
    run_sample(10'($urandom), 10'($urandom), 2, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_sample(10'($urandom), 10'($urandom), int'($urandom_range(0, 4)), 1'b0, 1'b1);

    // Enable dropped in WAIT_H: sample completes, then idle
    run_sample(10'($urandom), 10'($urandom), 1, 1'b1, 1'b0);
    reqs = 0;
    repeat (30) begin step(); if (adc_req) reqs++; end
    chk("idle_after_drop", 144'(reqs), 144'(0));

    latency_check("resume_lat");
    run_sample(10'($urandom), 10'($urandom), 1, 1'b0, 1'b1);

    // Reset while in WAIT_L, ack arrives during and after reset
    serve(chan_of(mot_m, 1'b0), 10'($urandom), 1, 1'b0);
    step();
    chk("wait_l", 144'({adc_req, adc_chan}), 144'({1'b1, chan_of(mot_m, 1'b1)}));
    rst_n = 1'b0; #1;
    model_reset();
    chk_all_zero("async_rst");
    step();
    adc_data = 10'd999; adc_ack = 1'b1; step(); adc_ack = 1'b0; enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    adc_ack = 1'b1; step(); adc_ack = 1'b0;
    reqs = 0;
    repeat (20) begin step(); if (adc_req) reqs++; end
    chk("idle_after_rst", 144'(reqs), 144'(0));
    chk_all_zero("post_rst");

    latency_check("rst_lat");
    run_sample(10'($urandom), 10'($urandom), 1, 1'b0, 1'b0);

`ifdef BEMF_ACC_CLEAR_EN
    // Motor 1: clear in WAIT_WB discards the pending write-back
    serve(chan_of(1, 1'b0), 10'd500, 2, 1'b0);
    serve(chan_of(1, 1'b1), 10'd20, 1, 1'b0);
    chk("clr_ov", 144'(out_valid), 144'(1));
    step();
    acc_clear = 4'b0010; step(); acc_clear = '0;
    acc_m[1] = '0;
    chk("clr_acc1", bemf_pos, pos_m());
    step();
    upd_valid = 1'b1; upd_sel = 2'd1; upd_bemf = 36'h123456789; step(); upd_valid = 1'b0;
    mot_m = 2;
    chk("clr_wb_drop", bemf_pos, pos_m());
    // Clear and write-back to the same motor in one cycle: clear wins
    acc_clear = 4'b1000; upd_valid = 1'b1; upd_sel = 2'd3; upd_bemf = 36'd77;
    step();
    acc_clear = '0; upd_valid = 1'b0;
    acc_m[3] = '0;
    chk("clr_vs_upd", bemf_pos, pos_m());
    serve(chan_of(2, 1'b0), 10'd1, 1, 1'b0);
    chk("clr_next_mot", 144'(adc_chan), 144'(chan_of(2, 1'b1)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
